// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer and flag controller for a 2**ADDR_W entry dual-port RAM.
// Wrap-bit pointers, registered level flags, and sticky error flags.
module fifo_ptr_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int AF_LEVEL = 240,
    parameter int AE_LEVEL = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] w_ptr,
    output logic [ADDR_W-1:0] r_ptr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] ZERO_C  = '0;

    logic [ADDR_W:0] w_q, w_d;
    logic [ADDR_W:0] r_q, r_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            af_q, af_d;
    logic            ae_q, ae_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            push_ok;
    logic            pop_ok;

    // Acceptance, pointer advance, occupancy and next-state flags.
    always_comb begin
        push_ok = push & ~full_q;
        pop_ok  = pop & ~empty_q;
        w_d     = w_q + {{ADDR_W{1'b0}}, push_ok};
        r_d     = r_q + {{ADDR_W{1'b0}}, pop_ok};
        count_d = w_d - r_d;
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == ZERO_C);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        ovf_d   = (push & full_q) | (ovf_q & ~clr_err);
        unf_d   = (pop & empty_q) | (unf_q & ~clr_err);
    end

    // State register; async reset returns to the empty FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q     <= '0;
            r_q     <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_q     <= w_d;
            r_q     <= r_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ram_we       = push_ok;
    assign ram_re       = pop_ok;
    assign w_ptr        = w_q[ADDR_W-1:0];
    assign r_ptr        = r_q[ADDR_W-1:0];
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Testbench for fifo_ptr_ctrl: scenario tasks plus randomized traffic
// checked against an occupancy-level reference model.
module tb_fifo_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] w_ptr, r_ptr;
    logic       ram_we, ram_re;
    logic [8:0] count;
    logic       full, empty, almost_full, almost_empty;
    logic       overflow, underflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: occupancy and pointer positions as plain integers.
    int   m_count = 0;
    int   m_w = 0;
    int   m_r = 0;
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;
    logic exp_we, exp_re;
    logic obs_we, obs_re;

    fifo_ptr_ctrl #(.ADDR_W(8), .AF_LEVEL(240), .AE_LEVEL(16)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .clr_err(clr_err), .w_ptr(w_ptr), .r_ptr(r_ptr),
        .ram_we(ram_we), .ram_re(ram_re), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    wire [30:0] dv = {w_ptr, r_ptr, count, full, empty,
                      almost_full, almost_empty, overflow, underflow};

    function automatic logic [30:0] exp_vec();
        int c = m_count;
        return {8'(m_w), 8'(m_r), 9'(c), c == 256, c == 0,
                c >= 240, c <= 16, m_ovf, m_unf};
    endfunction

    function automatic void model_reset();
        m_count = 0; m_w = 0; m_r = 0; m_ovf = 0; m_unf = 0;
    endfunction

    // One clock: drive, sample strobes before the edge, advance model.
    task automatic drive(input logic p, input logic q, input logic c);
        bit is_full, is_empty;
        push = p; pop = q; clr_err = c;
        #2;
        is_full  = (m_count == 256);
        is_empty = (m_count == 0);
        exp_we = p && !is_full;
        exp_re = q && !is_empty;
        obs_we = ram_we;
        obs_re = ram_re;
        @(posedge clk);
        m_w = (m_w + int'(exp_we)) % 256;
        m_r = (m_r + int'(exp_re)) % 256;
        m_count = m_count + int'(exp_we) - int'(exp_re);
        m_ovf = (p && is_full) || (m_ovf && !c);
        m_unf = (q && is_empty) || (m_unf && !c);
        #1;
        push = 0; pop = 0; clr_err = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) drive(0, 0, 0);
        n_cmp++;
        if (dv !== 31'({8'd0, 8'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0})) begin
            n_bad++;
            $display("FAIL reset_idle: got %h want empty-reset state", dv);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, 0);
            n_cmp++;
            if (obs_we !== 1'b1 || dv !== exp_vec()) begin
                n_bad++;
                $display("FAIL fill_%0d: we=%b vec=%h want %h",
                         i, obs_we, dv, exp_vec());
            end
        end
        n_cmp++;
        if (count !== 9'd256 || full !== 1'b1 || w_ptr !== 8'd0) begin
            n_bad++;
            $display("FAIL fill_full: count=%0d full=%b w=%0d want 256 1 0",
                     count, full, w_ptr);
        end
        drive(1, 0, 0);
        n_cmp++;
        if (obs_we !== 1'b0 || overflow !== 1'b1 || dv !== exp_vec()) begin
            n_bad++;
            $display("FAIL push_when_full: we=%b vec=%h want we=0 %h",
                     obs_we, dv, exp_vec());
        end
    endtask

    task automatic test_full_push_pop();
        drive(1, 1, 0);
        n_cmp++;
        if (obs_we !== 1'b0 || obs_re !== 1'b1 || count !== 9'd255 ||
            r_ptr !== 8'd1 || overflow !== 1'b1 || dv !== exp_vec()) begin
            n_bad++;
            $display("FAIL full_push_pop: we=%b re=%b vec=%h want 0 1 %h",
                     obs_we, obs_re, dv, exp_vec());
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(0, 1, 0);
        n_cmp++;
        if (obs_re !== 1'b0 || underflow !== 1'b1 || dv !== exp_vec()) begin
            n_bad++;
            $display("FAIL pop_when_empty: re=%b unf=%b want 0 1",
                     obs_re, underflow);
        end
        drive(1, 1, 0);
        n_cmp++;
        if (obs_we !== 1'b1 || obs_re !== 1'b0 || dv !== exp_vec()) begin
            n_bad++;
            $display("FAIL empty_push_pop: we=%b re=%b vec=%h want 1 0 %h",
                     obs_we, obs_re, dv, exp_vec());
        end
        drive(0, 0, 1);
        n_cmp++;
        if (underflow !== 1'b0 || dv !== exp_vec()) begin
            n_bad++;
            $display("FAIL clr_err: unf=%b vec=%h want 0 %h",
                     underflow, dv, exp_vec());
        end
        drive(0, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 1);
        n_cmp++;
        if (underflow !== 1'b1 || dv !== exp_vec()) begin
            n_bad++;
            $display("FAIL set_beats_clr: unf=%b want 1", underflow);
        end
    endtask

    task automatic test_steady();
        logic [7:0] d;
        do_reset();
        repeat (10) drive(1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 0);
            d = w_ptr - r_ptr;
            n_cmp++;
            if (d !== 8'd10 || count !== 9'd10 || dv !== exp_vec()) begin
                n_bad++;
                $display("FAIL steady_%0d: diff=%0d count=%0d vec=%h want 10 10 %h",
                         i, d, count, dv, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (100) drive(1, 0, 0);
        n_cmp++;
        if (count !== 9'd100) begin
            n_bad++;
            $display("FAIL preload_100: count=%0d want 100", count);
        end
        push = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dv !== exp_vec()) begin
            n_bad++;
            $display("FAIL async_reset: vec=%h want %h", dv, exp_vec());
        end
        push = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic p, q, c;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (((i / 300) % 2) == 0) begin
                p = ($urandom_range(3) != 0);
                q = ($urandom_range(3) == 0);
            end else begin
                p = ($urandom_range(3) == 0);
                q = ($urandom_range(3) != 0);
            end
            c = ($urandom_range(31) == 0);
            drive(p, q, c);
            n_cmp++;
            if (obs_we !== exp_we || obs_re !== exp_re || dv !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_%0d: we=%b re=%b vec=%h want %b %b %h",
                         i, obs_we, obs_re, dv, exp_we, exp_re, exp_vec());
            end
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_fill();
        test_full_push_pop();
        test_underflow();
        test_steady();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
